// File: rtl/fifo_pkg.sv
// Shared types and constants for the byte fifo and its read-side consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Width of one fifo entry; the packer and the fifo must agree on it.
    localparam int FIFO_DATA_W = 8;

    // Packer state: collecting bytes, or holding a finished word for downstream.
    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } pack_state_t;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter; tc flags the last idle cycle before the timeout fires.
// Latency: tc is combinational from the registered count (fires on the IDLE_TO-th idle cycle).
// Backpressure: none; clr has priority over en.
//
// Ports:
//   clk, rst  single clock, synchronous active-high reset
//   clr       zero the count this edge
//   en        count one idle cycle (saturates at IDLE_TO)
//   tc        count == IDLE_TO-1; constant 0 when IDLE_TO == 0 (timeout disabled)
module idle_timer #(
    parameter int IDLE_TO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // A zero-width counter is not legal, so a disabled timer keeps one idle bit.
    localparam int CNT_W = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;
    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(IDLE_TO);
    localparam logic [CNT_W-1:0] TERM_VAL = (IDLE_TO > 0) ? CNT_W'(IDLE_TO - 1) : '0;
    localparam logic             TIMER_ON = (IDLE_TO > 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT_VAL)) begin
            // Saturate rather than wrap so a long stall can never look fresh.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = TIMER_ON && (cnt_q == TERM_VAL);

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the fall-through byte fifo and packs BYTES of them into one output word.
// Latency: word valid the cycle after its last byte pops (or after flush / idle timeout).
// Backpressure: a held word stalls pops until m_ready; pop and accept overlap, no bubble.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   fifo_empty   fifo empty flag
//   fifo_rdata   fifo fall-through data, valid while !fifo_empty
//   fifo_read    pop strobe (combinational)
//   flush        one-cycle request to emit the current partial word
//   m_data       packed word, first popped byte in lane 0 (bits DATA_W-1:0)
//   m_keep       per-lane valid mask
//   m_valid      word valid
//   m_ready      downstream accept
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int BYTES   = 4,
    parameter int IDLE_TO = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    input  logic [DATA_W-1:0]       fifo_rdata,
    output logic                    fifo_read,
    input  logic                    flush,
    output logic [BYTES*DATA_W-1:0] m_data,
    output logic [BYTES-1:0]        m_keep,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int               CNT_W     = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES - 1);

    pack_state_t             state_q, state_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [BYTES*DATA_W-1:0] data_q, data_d;
    logic [BYTES-1:0]        keep_q, keep_d;

    logic pop;
    logic have_bytes;
    logic idle_clr;
    logic idle_en;
    logic idle_tc;

    assign have_bytes = (byte_cnt_q != '0);

    // In SEND the pop is only allowed on the cycle the held word is accepted,
    // so the lane-0 byte of the next word is taken without a dead cycle.
    assign pop = !rst && !fifo_empty &&
                 ((state_q == FILL) || ((state_q == SEND) && m_ready));

    // Idle cycles only matter while a partial word is waiting in FILL.
    assign idle_en  = (state_q == FILL) && have_bytes && !pop;
    assign idle_clr = !idle_en;

    idle_timer #(
        .IDLE_TO (IDLE_TO)
    ) u_idle_timer (
        .clk (clk),
        .rst (rst),
        .clr (idle_clr),
        .en  (idle_en),
        .tc  (idle_tc)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        keep_d     = keep_q;

        case (state_q)
            FILL: begin
                if (pop) begin
                    // Loop-compare instead of a variable index keeps the lane
                    // select exactly as wide as the lane count.
                    for (int i = 0; i < BYTES; i++) begin
                        if (byte_cnt_q == CNT_W'(i)) begin
                            data_d[i*DATA_W +: DATA_W] = fifo_rdata;
                            keep_d[i]                  = 1'b1;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end

                if (pop && (byte_cnt_q == LAST_LANE)) begin
                    state_d    = SEND;
                    byte_cnt_d = '0;
                end else if (have_bytes && (flush || (idle_tc && !pop))) begin
                    // Partial word; a byte popped alongside the flush is already
                    // folded into data_d/keep_d above.
                    state_d    = SEND;
                    byte_cnt_d = '0;
                end
            end

            SEND: begin
                if (m_ready) begin
                    state_d    = FILL;
                    data_d     = '0;
                    keep_d     = '0;
                    byte_cnt_d = '0;
                    if (pop) begin
                        data_d[DATA_W-1:0] = fifo_rdata;
                        keep_d[0]          = 1'b1;
                        byte_cnt_d         = CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            byte_cnt_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
        end
    end

    assign fifo_read = pop;
    assign m_valid   = (state_q == SEND);
    assign m_data    = data_q;
    assign m_keep    = keep_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (BYTES=4, IDLE_TO=16) with a random soak at the end.
// Latency: n/a.
// Backpressure: bench drives m_ready and a forced-empty mask on the fifo model.
module tb_fifo_word_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_read;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;

    // Simple fall-through fifo model.
    logic [7:0]  mem [256];
    logic [15:0] wr_ptr;
    logic [15:0] rd_ptr;
    logic        hold_empty;

    int n_assert;
    int n_fail;

    logic [7:0]  exp_q [$];
    logic        held;
    logic [31:0] held_data;
    logic [3:0]  held_keep;
    logic [7:0]  rb;

    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;
    assign fifo_rdata = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_read && (wr_ptr != rd_ptr)) begin
            rd_ptr <= rd_ptr + 16'd1;
        end
    end

    fifo_word_packer #(
        .DATA_W  (8),
        .BYTES   (4),
        .IDLE_TO (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_read  (fifo_read),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    // Called just before the posedge at which m_valid && m_ready completes a handshake.
    task automatic score();
        int cnt;
        logic [7:0] eb;
        cnt = $countones(m_keep);
        chk("r_word_nonempty", 64'(cnt != 0), 64'd1);
        chk("r_keep_contig", 64'(m_keep), 64'((1 << cnt) - 1));
        for (int i = 0; i < 4; i++) begin
            if (i < cnt) begin
                chk("r_queue_has_byte", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    chk("r_byte_order", 64'(m_data[i*8 +: 8]), 64'(eb));
                end
            end else begin
                chk("r_idle_lane_zero", 64'(m_data[i*8 +: 8]), 64'd0);
            end
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        wr_ptr     = '0;
        rd_ptr     = '0;
        rst        = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        hold_empty = 1'b0;
        held       = 1'b0;
        held_data  = '0;
        held_keep  = '0;

        // Reset state, with the test-1 bytes already waiting in the fifo.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick(); tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_no_pop", 64'(fifo_read), 64'd0);

        // 1. Full word, valid for exactly one cycle with m_ready=1.
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_not_yet", 64'(m_valid), 64'd0);
        end
        tick();
        chk("full_valid", 64'(m_valid), 64'd1);
        chk("full_data", 64'(m_data), 64'h44332211);
        chk("full_keep", 64'(m_keep), 64'hF);
        chk("full_pops", 64'(rd_ptr), 64'd4);
        tick();
        chk("full_one_cycle", 64'(m_valid), 64'd0);
        chk("full_pops_after", 64'(rd_ptr), 64'd4);

        // 2. Back-pressure: word held with no pops, then second word without a bubble.
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        tick(); tick(); tick(); tick();
        chk("bp_first_valid", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'hF, 32'h04030201}));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", 64'({fifo_read, m_valid, m_data}), 64'({1'b0, 1'b1, 32'h04030201}));
        end
        m_ready = 1'b1;
        tick();
        chk("bp_accept_pop", 64'({m_valid, m_keep, m_data}), 64'({1'b0, 4'h1, 32'h00000005}));
        tick();
        chk("bp_gap1", 64'(m_valid), 64'd0);
        tick();
        chk("bp_gap2", 64'(m_valid), 64'd0);
        tick();
        chk("bp_second_word", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'hF, 32'h08070605}));
        tick();
        chk("bp_second_taken", 64'(m_valid), 64'd0);

        // 3. Timeout: two bytes then idle; valid 16 cycles after the last pop.
        push(8'hAA); push(8'hBB);
        tick(); tick();
        for (int i = 3; i <= 17; i++) begin
            tick();
            chk("to_wait", 64'(m_valid), 64'd0);
        end
        tick();
        chk("to_word", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'h3, 32'h0000BBAA}));
        tick();
        chk("to_taken", 64'(m_valid), 64'd0);

        // 4. Flush: three bytes then a pulse; empty flush ignored; same-cycle pop included.
        push(8'hC1); push(8'hC2); push(8'hC3);
        tick(); tick(); tick();
        chk("fl_not_yet", 64'(m_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_word", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'h7, 32'h00C3C2C1}));
        tick();
        chk("fl_taken", 64'(m_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_ignored", 64'(m_valid), 64'd0);
        tick();
        chk("fl_empty_ignored2", 64'({m_valid, m_keep}), 64'd0);
        push(8'hD1);
        tick();
        push(8'hD2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_with_pop", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'h3, 32'h0000D2D1}));
        tick();
        chk("fl_with_pop_taken", 64'(m_valid), 64'd0);

        // 5. Reset mid-fill discards the partial word.
        push(8'hE1); push(8'hE2);
        tick(); tick();
        rst = 1'b1;
        chk("rmid_no_pop", 64'(fifo_read), 64'd0);
        chk("rmid_valid", 64'(m_valid), 64'd0);
        tick();
        rst = 1'b0;
        chk("rmid_cleared", 64'({m_valid, m_keep, m_data}), 64'd0);
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rmid_no_stale", 64'(m_valid), 64'd0);
        end
        tick();
        chk("rmid_word", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'hF, 32'hF4F3F2F1}));
        tick();
        chk("rmid_taken", 64'(m_valid), 64'd0);

        // 6. Random soak: never pop empty, held word stable, byte order preserved.
        exp_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (held) begin
                chk("r_hold_stable", 64'({m_valid, m_keep, m_data}), 64'({1'b1, held_keep, held_data}));
            end
            hold_empty = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 30) == 0);
            if (((wr_ptr - rd_ptr) < 16'd16) && ($urandom_range(0, 1) == 1)) begin
                rb = 8'($urandom);
                push(rb);
                exp_q.push_back(rb);
            end
            #1;
            chk("r_no_pop_empty", 64'(fifo_read && fifo_empty), 64'd0);
            if (m_valid && m_ready) score();
            held      = m_valid && !m_ready;
            held_data = m_data;
            held_keep = m_keep;
            tick();
        end

        // Drain: leftovers leave through the idle timeout.
        hold_empty = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b1;
        held       = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (m_valid && m_ready) score();
            tick();
        end
        chk("r_all_bytes_out", 64'(exp_q.size()), 64'd0);
        chk("r_fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);
        chk("r_idle_end", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
